// File: rtl/flag_branch_ctrl_pkg.sv
// NZCV flag types, condition codes and the B.cond evaluator.
// Shared by flag_branch_ctrl and its testbench.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic {
    IDLE,
    WAIT
  } fbc_state_e;

  function automatic logic cond_true(
    cond_e  c,
    flags_t f
  );
    logic r;
    r = 1'b1;
    case (c)
      EQ: r = f.z;
      NE: r = !f.z;
      HS: r = f.c;
      LO: r = !f.c;
      MI: r = f.n;
      PL: r = !f.n;
      VS: r = f.v;
      VC: r = !f.v;
      HI: r = f.c & !f.z;
      LS: r = !f.c | f.z;
      GE: r = (f.n == f.v);
      LT: r = (f.n != f.v);
      GT: r = !f.z & (f.n == f.v);
      LE: r = f.z | (f.n != f.v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// EX/ID side bundle of flag_branch_ctrl.
// master drives the pipeline inputs, slave is the controller.
interface flag_branch_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              ex_valid;
  logic              ex_set_flags;
  logic [DATA_W-1:0] ex_result;
  logic              ex_carry;
  logic              ex_overflow;
  logic              pipe_stall;
  logic              flush;
  logic              id_valid;
  logic              id_is_bcond;
  logic [3:0]        id_cond;
  logic              id_is_cbz;
  logic              id_cbnz;
  logic [DATA_W-1:0] id_cbz_val;
  logic              br_resolved;
  logic              br_taken;
  logic              flag_stall;
  logic [3:0]        flags_q;

  modport master (
    output ex_valid, ex_set_flags, ex_result,
    output ex_carry, ex_overflow,
    output pipe_stall, flush,
    output id_valid, id_is_bcond, id_cond,
    output id_is_cbz, id_cbnz, id_cbz_val,
    input  br_resolved, br_taken,
    input  flag_stall, flags_q
  );

  modport slave (
    input  ex_valid, ex_set_flags, ex_result,
    input  ex_carry, ex_overflow,
    input  pipe_stall, flush,
    input  id_valid, id_is_bcond, id_cond,
    input  id_is_cbz, id_cbnz, id_cbz_val,
    output br_resolved, br_taken,
    output flag_stall, flags_q
  );
endinterface

// File: rtl/flag_branch_ctrl_zero_detect_tree.sv
// Chunked zero detect: NOR per CHUNK_W slice, then AND of slices.
// DATA_W must be a multiple of CHUNK_W.
module zero_detect_tree #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic [DATA_W-1:0] data,
  output logic              zero
);
  localparam int NCH = DATA_W / CHUNK_W;

  logic [NCH-1:0] chunk_zero;

  for (genvar i = 0; i < NCH; i++) begin : g_chunk
    assign chunk_zero[i] = ~|data[i*CHUNK_W +: CHUNK_W];
  end

  assign zero = &chunk_zero;
endmodule

// File: rtl/flag_branch_ctrl.sv
// NZCV register, ID branch resolution and flag RAW hazard control.
// FLAG_FWD_EN: forward live EX flags instead of a one-cycle stall.
module flag_branch_ctrl
  import flag_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  flag_branch_ctrl_if.slave bus
);
  logic   ex_zero;
  logic   cbz_zero;
  logic   hz;
  logic   stall;
  logic   hold;
  logic   cond_ok;
  flags_t ex_flags;
  flags_t flags_r;
  flags_t eval_flags;

  zero_detect_tree #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) u_ex_zd (
    .data (bus.ex_result),
    .zero (ex_zero)
  );

  zero_detect_tree #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) u_cbz_zd (
    .data (bus.id_cbz_val),
    .zero (cbz_zero)
  );

  assign ex_flags = {bus.ex_result[DATA_W-1], ex_zero,
                     bus.ex_carry, bus.ex_overflow};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flags_r <= '0;
    else if (bus.ex_valid & bus.ex_set_flags & !bus.pipe_stall)
      flags_r <= ex_flags;
  end

  assign hz = bus.id_valid & bus.id_is_bcond
            & bus.ex_valid & bus.ex_set_flags;

`ifdef FLAG_FWD_EN
  assign stall      = 1'b0;
  assign hold       = 1'b0;
  assign eval_flags = hz ? ex_flags : flags_r;
`else
  fbc_state_e state;
  fbc_state_e state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (hz & !bus.pipe_stall & !bus.flush)
          state_nx = WAIT;
      WAIT:
        if (bus.flush | !bus.pipe_stall)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // the hazard cycle itself must not resolve on stale flags
  assign stall      = (state == WAIT);
  assign hold       = hz;
  assign eval_flags = flags_r;
`endif

  assign cond_ok = cond_true(cond_e'(bus.id_cond), eval_flags);

  assign bus.br_resolved = reset_n & bus.id_valid
                         & (bus.id_is_bcond | bus.id_is_cbz)
                         & !bus.flush & !bus.pipe_stall
                         & !stall & !hold;

  assign bus.br_taken = bus.br_resolved
                      & (bus.id_is_cbz
                         ? (cbz_zero ^ bus.id_cbnz)
                         : cond_ok);

  assign bus.flag_stall = reset_n & stall;
  assign bus.flags_q    = flags_r;
endmodule
